// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
package fetch_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, HALT} fetch_state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_RANGE} fetch_err_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: sequential/redirect PC selection, wrong-path squash,
// refill bubbles after a redirect, and sticky halt/error freeze.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W        = 9,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             halt,
    output logic [PC_W-1:0]  PC,
    output logic             fetch_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

    fetch_state_e    state_reg, state_next;
    fetch_err_e      err_reg, err_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [2:0]      flush_cnt_reg, flush_cnt_next;
    logic            redirect_ok;
    logic            flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RUN;
            err_reg       <= ERR_NONE;
            pc_reg        <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            err_reg       <= err_next;
            pc_reg        <= pc_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        err_next       = err_reg;
        pc_next        = pc_reg;
        flush_cnt_next = flush_cnt_reg;
        redirect_ok    = 1'b0;
        flush          = 1'b0;
        fetch_valid    = 1'b0;
        halted         = 1'b0;
        case (state_reg)
            RUN: begin
                fetch_valid = 1'b1;
                if (halt) begin
                    state_next = HALT;
                end else if (PcSel) begin
                    // Wrong-path instructions are squashed even when the target is bad.
                    flush = 1'b1;
                    if (BrPC[1:0] != 2'b00) begin
                        state_next = HALT;
                        err_next   = ERR_MISALIGN;
                    end else if (BrPC[31:PC_W] != '0) begin
                        state_next = HALT;
                        err_next   = ERR_RANGE;
                    end else begin
                        redirect_ok    = 1'b1;
                        pc_next        = BrPC[PC_W-1:0];
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_INIT;
                    end
                end else if (!stall) begin
                    pc_next = pc_reg + PC_W'(PC_STEP);
                end
            end
            FLUSH: begin
                // Stall and PcSel are ignored while the IMEM refills.
                if (halt) begin
                    state_next = HALT;
                end else if (flush_cnt_reg <= 3'd1) begin
                    state_next     = RUN;
                    flush_cnt_next = '0;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 3'd1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (redirect_ok),
        .q       (redirect_cnt)
    );

    assign PC         = pc_reg;
    assign flush_ifid = flush;
    assign flush_idex = flush;
    assign err        = err_reg;

endmodule
